// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and arbiter state.
// Imported by the ALU front-end arbiter and its users.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [2:0] FUNC3_ADD  = 3'b000;
    localparam logic [2:0] FUNC3_SLL  = 3'b001;
    localparam logic [2:0] FUNC3_SLT  = 3'b010;
    localparam logic [2:0] FUNC3_SLTU = 3'b011;
    localparam logic [2:0] FUNC3_XOR  = 3'b100;
    localparam logic [2:0] FUNC3_SRX  = 3'b101;
    localparam logic [2:0] FUNC3_OR   = 3'b110;
    localparam logic [2:0] FUNC3_AND  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first asserted request at or above ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    // Scan requests starting at ptr; the first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req[ID_W'(idx)]) begin
                gnt_any             = 1'b1;
                gnt_oh[ID_W'(idx)]  = 1'b1;
                gnt_id              = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-output ALU between NREQ requesters.
// Round-robin grant, held operands, tagged valid/ready response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREQ   = 2,
    parameter int ID_W   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DATA_W-1:0] req_in1,
    input  logic [NREQ*DATA_W-1:0] req_in2,
    input  logic [NREQ*3-1:0]    req_func3,
    input  logic [NREQ-1:0]      req_opequal,
    output logic [DATA_W-1:0]    alu_in1,
    output logic [DATA_W-1:0]    alu_in2,
    output logic [2:0]           alu_func3,
    output logic                 alu_opequal,
    input  logic [DATA_W-1:0]    alu_out,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [DATA_W-1:0]    rsp_data,
    input  logic                 rsp_ready
);

    arb_state_e        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] in1_q;
    logic [DATA_W-1:0] in2_q;
    logic [2:0]        f3_q;
    logic              opeq_q;

    logic [NREQ-1:0]   gnt_oh;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic              can_take;
    logic              take;
    logic [ID_W-1:0]   nxt_ptr;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    // A new op may enter when idle, or when the current result is
    // being consumed this cycle; reset and flush block everything.
    assign can_take = rst_n && !flush &&
                      (state == IDLE || (state == RESP && rsp_ready));
    assign req_ready = can_take ? gnt_oh : '0;
    assign take      = can_take && gnt_any;

    assign rsp_valid = rst_n && !flush && (state == RESP);
    assign rsp_data  = rsp_valid ? alu_out : '0;
    assign rsp_id    = id_q;

    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_func3   = f3_q;
    assign alu_opequal = opeq_q;

    assign nxt_ptr = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;

    // Op FSM plus operand/id capture on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
            f3_q   <= '0;
            opeq_q <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (take) state <= ISSUE;
                ISSUE:   state <= RESP;
                RESP:    if (rsp_ready) state <= take ? ISSUE : IDLE;
                default: state <= IDLE;
            endcase
            if (take) begin
                rr_ptr <= nxt_ptr;
                id_q   <= gnt_id;
                in1_q  <= req_in1[gnt_id*DATA_W +: DATA_W];
                in2_q  <= req_in2[gnt_id*DATA_W +: DATA_W];
                f3_q   <= req_func3[gnt_id*3 +: 3];
                opeq_q <= req_opequal[gnt_id];
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered ALU alongside.
// Inputs change 2 time units after posedge; outputs checked 1 later.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_in1;
    logic [63:0] req_in2;
    logic [5:0]  req_func3;
    logic [1:0]  req_opequal;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [2:0]  alu_func3;
    logic        alu_opequal;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready;

    logic [31:0] r_in1 [2];
    logic [31:0] r_in2 [2];
    logic [2:0]  r_f3  [2];
    logic        r_opq [2];

    int n_tests = 0;
    int n_fail  = 0;

    assign req_in1     = {r_in1[1], r_in1[0]};
    assign req_in2     = {r_in2[1], r_in2[0]};
    assign req_func3   = {r_f3[1], r_f3[0]};
    assign req_opequal = {r_opq[1], r_opq[0]};

    always #5 clk = ~clk;

    alu_arbiter #(
        .DATA_W (32),
        .NREQ   (2),
        .ID_W   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_in1     (req_in1),
        .req_in2     (req_in2),
        .req_func3   (req_func3),
        .req_opequal (req_opequal),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_func3   (alu_func3),
        .alu_opequal (alu_opequal),
        .alu_out     (alu_out),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready)
    );

    function automatic logic [31:0] alu_f(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  f3,
        input logic        q
    );
        logic [31:0] r;
        r = '0;
        case (f3)
            FUNC3_ADD:  r = q ? a - b : a + b;
            FUNC3_SLL:  r = a << b[4:0];
            FUNC3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            FUNC3_SLTU: r = {31'b0, a < b};
            FUNC3_XOR:  r = a ^ b;
            FUNC3_SRX:  r = q ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            FUNC3_OR:   r = a | b;
            default:    r = a & b;
        endcase
        return r;
    endfunction

    // Reference ALU: one-cycle registered result.
    always_ff @(posedge clk)
        alu_out <= alu_f(alu_in1, alu_in2, alu_func3, alu_opequal);

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(
        input int          i,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  f3,
        input logic        q
    );
        r_in1[i] = a;
        r_in2[i] = b;
        r_f3[i]  = f3;
        r_opq[i] = q;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        flush     = 1'b0;
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        set_req(0, 0, 0, FUNC3_ADD, 1'b0);
        set_req(1, 0, 0, FUNC3_ADD, 1'b0);

        // Reset state
        req_valid = 2'b11;
        nxt();
        nxt();
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_data", rsp_data, 32'd0);

        // 1: single SUB 5-3 from req0
        nxt();
        rst_n     = 1'b1;
        req_valid = 2'b01;
        set_req(0, 32'd5, 32'd3, FUNC3_ADD, 1'b1);
        #1;
        check("s1_ready", 32'(req_ready), 32'd1);
        nxt();
        req_valid = 2'b00;
        #1;
        check("s1_issue_valid", 32'(rsp_valid), 32'd0);
        check("s1_alu_in1", alu_in1, 32'd5);
        check("s1_alu_in2", alu_in2, 32'd3);
        check("s1_alu_opq", 32'(alu_opequal), 32'd1);
        nxt();
        #1;
        check("s1_valid", 32'(rsp_valid), 32'd1);
        check("s1_id", 32'(rsp_id), 32'd0);
        check("s1_data", rsp_data, 32'd2);
        nxt();
        #1;
        check("s1_done_valid", 32'(rsp_valid), 32'd0);
        check("s1_done_data", rsp_data, 32'd0);

        // 2: both requesters continuously valid, alternating grants
        do_reset();
        set_req(0, 32'd1, 32'd1, FUNC3_ADD, 1'b0);
        set_req(1, 32'hF0, 32'h0F, FUNC3_XOR, 1'b0);
        req_valid = 2'b11;
        #1;
        check("s2_first_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            nxt();
            #1;
            check("s2_issue_valid", 32'(rsp_valid), 32'd0);
            nxt();
            if (k == 3) req_valid = 2'b00;
            #1;
            check("s2_valid", 32'(rsp_valid), 32'd1);
            check("s2_id", 32'(rsp_id), 32'(k % 2));
            check("s2_data", rsp_data, (k % 2 == 1) ? 32'hFF : 32'd2);
            check("s2_ready", 32'(req_ready),
                  (k == 3) ? 32'd0 : ((k % 2 == 1) ? 32'd1 : 32'd2));
        end
        nxt();
        #1;
        check("s2_idle_valid", 32'(rsp_valid), 32'd0);

        // 3: req1 SRA with consumer stalled, then back-to-back (6)
        nxt();
        set_req(1, 32'h8000_0000, 32'd4, FUNC3_SRX, 1'b1);
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        #1;
        check("s3_ready", 32'(req_ready), 32'd2);
        nxt();
        set_req(0, 32'd7, 32'd8, FUNC3_ADD, 1'b0);
        req_valid = 2'b01;
        #1;
        check("s3_issue_ready", 32'(req_ready), 32'd0);
        nxt();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("s3_stall_valid", 32'(rsp_valid), 32'd1);
            check("s3_stall_id", 32'(rsp_id), 32'd1);
            check("s3_stall_data", rsp_data, 32'hF800_0000);
            check("s3_stall_ready", 32'(req_ready), 32'd0);
            nxt();
        end
        rsp_ready = 1'b1;
        #1;
        check("s6_hs_valid", 32'(rsp_valid), 32'd1);
        check("s6_hs_ready", 32'(req_ready), 32'd1);
        nxt();
        req_valid = 2'b00;
        #1;
        check("s6_issue_valid", 32'(rsp_valid), 32'd0);
        nxt();
        #1;
        check("s6_valid", 32'(rsp_valid), 32'd1);
        check("s6_id", 32'(rsp_id), 32'd0);
        check("s6_data", rsp_data, 32'h0000_000F);

        // 4: flush while result is being offered
        nxt();
        set_req(0, 32'hFF00, 32'h0FF0, FUNC3_AND, 1'b0);
        req_valid = 2'b01;
        #1;
        check("s4_ready", 32'(req_ready), 32'd1);
        nxt();
        set_req(1, 32'd10, 32'd20, FUNC3_ADD, 1'b0);
        req_valid = 2'b10;
        #1;
        check("s4_issue_ready", 32'(req_ready), 32'd0);
        nxt();
        #1;
        check("s4_pre_valid", 32'(rsp_valid), 32'd1);
        check("s4_pre_data", rsp_data, 32'h0F00);
        check("s4_pre_ready", 32'(req_ready), 32'd2);
        flush = 1'b1;
        #1;
        check("s4_fl_valid", 32'(rsp_valid), 32'd0);
        check("s4_fl_ready", 32'(req_ready), 32'd0);
        check("s4_fl_data", rsp_data, 32'd0);
        nxt();
        flush     = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("s4_after_valid", 32'(rsp_valid), 32'd0);
            nxt();
        end
        req_valid = 2'b11;
        #1;
        check("s4_ptr_kept", 32'(req_ready), 32'd2);
        nxt();
        req_valid = 2'b00;
        nxt();
        #1;
        check("s4_new_valid", 32'(rsp_valid), 32'd1);
        check("s4_new_id", 32'(rsp_id), 32'd1);
        check("s4_new_data", rsp_data, 32'h1E);

        // 5: reset while an op is in ISSUE
        nxt();
        req_valid = 2'b01;
        #1;
        check("s5_ready", 32'(req_ready), 32'd1);
        nxt();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        check("s5_rst_ready", 32'(req_ready), 32'd0);
        check("s5_rst_valid", 32'(rsp_valid), 32'd0);
        nxt();
        rst_n = 1'b1;
        #1;
        check("s5_post_valid", 32'(rsp_valid), 32'd0);
        check("s5_post_ptr", 32'(req_ready), 32'd1);
        set_req(1, 32'd1, 32'd4, FUNC3_SLL, 1'b0);
        req_valid = 2'b10;
        #1;
        check("s5_req1_ready", 32'(req_ready), 32'd2);
        nxt();
        req_valid = 2'b00;
        #1;
        check("s5_issue_valid", 32'(rsp_valid), 32'd0);
        nxt();
        #1;
        check("s5_valid", 32'(rsp_valid), 32'd1);
        check("s5_id", 32'(rsp_id), 32'd1);
        check("s5_data", rsp_data, 32'h10);
        nxt();
        #1;
        check("s5_idle_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
